instr_sequencer: RTL

Host-side driver for the lab CPU's instruction port. It holds a small instruction buffer written by the host. On `go` it issues each stored instruction to the CPU in order, using the CPU's `load` / `start` / `waiting` protocol, and captures the CPU's `out` and N/V/Z flags after each instruction completes. It sits between the host/testbench and the `cpu` block, and provides timeout detection and a retired-instruction count.

---
 rtl/instr_sequencer.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : instr_sequencer
// Purpose  : Host-written instruction buffer replayed to the CPU through the
//            load/start/waiting handshake, with result capture and timeout.
// Revision : 1.0
// ============================================================================
module instr_sequencer #(
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 255,
    localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [15:0]   wr_data,
    input  logic [AW:0]   prog_len,
    input  logic          go,
    output logic          cpu_load,
    output logic          cpu_start,
    output logic [15:0]   cpu_instr,
    input  logic          cpu_waiting,
    input  logic [15:0]   cpu_out,
    input  logic          cpu_N,
    input  logic          cpu_V,
    input  logic          cpu_Z,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [15:0]   result,
    output logic [2:0]    flags,
    output logic [AW-1:0] pc,
    output logic [AW:0]   retired
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] c_TO_LAST = TW'(TIMEOUT - 1);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_LOAD  = 3'd1;
    localparam logic [2:0] c_START = 3'd2;
    localparam logic [2:0] c_ACK   = 3'd3;
    localparam logic [2:0] c_EXEC  = 3'd4;
    localparam logic [2:0] c_CAPT  = 3'd5;

    logic [2:0]    r_state;
    logic [15:0]   r_mem [DEPTH];
    logic [AW:0]   r_len;
    logic [TW-1:0] r_cnt;
    logic          r_load;
    logic          r_start;
    logic [15:0]   r_instr;
    logic          r_done;
    logic          r_err;
    logic [15:0]   r_result;
    logic [2:0]    r_flags;
    logic [AW-1:0] r_pc;
    logic [AW:0]   r_retired;

    logic          w_busy;
    logic          w_last;
    logic          w_timeout;
    logic [AW-1:0] w_next_pc;

    assign w_busy    = (r_state != c_IDLE);
    assign w_last    = ({1'b0, r_pc} == (r_len - (AW+1)'(1)));
    assign w_timeout = (r_cnt == c_TO_LAST);
    assign w_next_pc = r_pc + AW'(1);

    // Storage is deliberately outside the reset domain so programs survive rst_n.
    always_ff @(posedge clk) begin
        if (wr_en && !w_busy) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= c_IDLE;
            r_len     <= '0;
            r_cnt     <= '0;
            r_load    <= 1'b0;
            r_start   <= 1'b0;
            r_instr   <= '0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_result  <= '0;
            r_flags   <= '0;
            r_pc      <= '0;
            r_retired <= '0;
        end else begin
            r_load  <= 1'b0;
            r_start <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (go) begin
                        r_done    <= 1'b0;
                        r_err     <= 1'b0;
                        r_retired <= '0;
                        r_pc      <= '0;
                        r_len     <= prog_len;
                        if (prog_len == '0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_instr <= r_mem[0];
                            r_load  <= 1'b1;
                            r_state <= c_LOAD;
                        end
                    end
                end
                c_LOAD: begin
                    r_start <= 1'b1;
                    r_state <= c_START;
                end
                c_START: begin
                    r_cnt   <= '0;
                    r_state <= c_ACK;
                end
                c_ACK: begin
                    // An accepted instruction wins over a coincident timeout.
                    if (!cpu_waiting) begin
                        r_cnt   <= '0;
                        r_state <= c_EXEC;
                    end else if (w_timeout) begin
                        r_err   <= 1'b1;
                        r_state <= c_IDLE;
                    end else begin
                        r_cnt <= r_cnt + TW'(1);
                    end
                end
                c_EXEC: begin
                    if (cpu_waiting) begin
                        r_state <= c_CAPT;
                    end else if (w_timeout) begin
                        r_err   <= 1'b1;
                        r_state <= c_IDLE;
                    end else begin
                        r_cnt <= r_cnt + TW'(1);
                    end
                end
                c_CAPT: begin
                    r_result  <= cpu_out;
                    r_flags   <= {cpu_N, cpu_V, cpu_Z};
                    r_retired <= r_retired + (AW+1)'(1);
                    if (w_last) begin
                        r_done  <= 1'b1;
                        r_state <= c_IDLE;
                    end else begin
                        r_pc    <= w_next_pc;
                        r_instr <= r_mem[w_next_pc];
                        r_load  <= 1'b1;
                        r_state <= c_LOAD;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign cpu_load  = r_load;
    assign cpu_start = r_start;
    assign cpu_instr = r_instr;
    assign busy      = w_busy;
    assign done      = r_done;
    assign err       = r_err;
    assign result    = r_result;
    assign flags     = r_flags;
    assign pc        = r_pc;
    assign retired   = r_retired;

endmodule
`default_nettype wire
